// File: rtl/commit_trace_buffer_if.sv
// rtl/commit_trace_buffer_if.sv - trace word stream between the commit trace buffer and the debug link
interface commit_trace_buffer_if;
    logic        tr_valid;
    logic        tr_ready;
    logic [31:0] tr_data;
    logic        tr_last;

    modport master (
        output tr_valid,
        output tr_data,
        output tr_last,
        input  tr_ready
    );

    modport slave (
        input  tr_valid,
        input  tr_data,
        input  tr_last,
        output tr_ready
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - commit trace capture FIFO, CPU throttle and word serializer (TRACE_DMEM_EN adds dmem words)
module commit_trace_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  commit,
    input  logic                  commit_halt,
    input  logic                  commit_reg_we,
    input  logic                  commit_dmem_we,
    input  logic [31:0]           commit_pc,
    input  logic [31:0]           commit_inst,
    input  logic [31:0]           commit_reg_wd,
    input  logic [31:0]           commit_dmem_wa,
    input  logic [31:0]           commit_dmem_wd,
    input  logic [4:0]            commit_reg_wa,
    output logic                  cpu_en,
    output logic                  done,
    output logic                  overflow,
    commit_trace_buffer_if.master tr
);

    localparam int AW = $clog2(DEPTH);
`ifdef TRACE_DMEM_EN
    localparam int W = 6;
`else
    localparam int W = 4;
`endif
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {IDLE, RUN, HALTED, DONE} state_t;

    state_t               state;
    logic [W-1:0][31:0]   mem [DEPTH];
    logic [W-1:0][31:0]   entry_in;
    logic [W-1:0][31:0]   head;
    logic [31:0]          flags_word;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic [AW+1:0]        occ_next;
    logic [IW-1:0]        widx;
    logic                 en_q;
    logic                 cap;
    logic                 empty;
    logic                 full;
    logic                 xfer;
    logic                 pop;
    logic                 push;

    // A commit is only new if the CPU was enabled on the edge that produced it.
    assign cap   = commit & en_q;
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign xfer  = !empty && tr.tr_ready;
    assign pop   = xfer && (widx == LAST_IDX);
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push  = cap && (!full || pop);

    // Keep one slot in reserve for the commit that is already in flight.
    assign occ_next = {1'b0, count} + {{(AW + 1){1'b0}}, cap};
    assign cpu_en   = (state == RUN) && (occ_next < {1'b0, DEPTH_C});

    assign flags_word = {commit_halt, commit_reg_we, commit_dmem_we, 24'h0, commit_reg_wa};
`ifdef TRACE_DMEM_EN
    assign entry_in = {commit_dmem_wd, commit_dmem_wa, commit_reg_wd, flags_word, commit_inst, commit_pc};
`else
    logic unused_dmem;
    assign unused_dmem = ^{commit_dmem_wa, commit_dmem_wd};
    assign entry_in = {commit_reg_wd, flags_word, commit_inst, commit_pc};
`endif

    assign head        = mem[rd_ptr];
    assign tr.tr_valid = !empty;
    assign tr.tr_data  = empty ? 32'h0 : head[widx];
    assign tr.tr_last  = !empty && (widx == LAST_IDX);

    // Entry storage; contents are don't-care while count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // FIFO pointers, occupancy, word index and overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            widx     <= '0;
            en_q     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            en_q <= cpu_en;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (xfer) begin
                widx <= pop ? '0 : widx + IDX_ONE;
            end
            if (cap && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Tracing control: run until a halt is captured, then drain and report done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= (state == DONE) && !start;
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (cap && commit_halt) state <= HALTED;
                HALTED:  if (empty) state <= DONE;
                DONE:    if (start) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - scoreboard bench for commit_trace_buffer driven by a throttled CPU model
module tb_commit_trace_buffer;

    localparam int DEPTH = 16;
`ifdef TRACE_DMEM_EN
    localparam int W = 6;
`else
    localparam int W = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        commit = 1'b0;
    logic        commit_halt = 1'b0;
    logic        commit_reg_we = 1'b0;
    logic        commit_dmem_we = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_inst = '0;
    logic [31:0] commit_reg_wd = '0;
    logic [31:0] commit_dmem_wa = '0;
    logic [31:0] commit_dmem_wd = '0;
    logic [4:0]  commit_reg_wa = '0;
    logic        cpu_en;
    logic        done;
    logic        overflow;

    commit_trace_buffer_if tr_if ();

    commit_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .commit         (commit),
        .commit_halt    (commit_halt),
        .commit_reg_we  (commit_reg_we),
        .commit_dmem_we (commit_dmem_we),
        .commit_pc      (commit_pc),
        .commit_inst    (commit_inst),
        .commit_reg_wd  (commit_reg_wd),
        .commit_dmem_wa (commit_dmem_wa),
        .commit_dmem_wd (commit_dmem_wd),
        .commit_reg_wa  (commit_reg_wa),
        .cpu_en         (cpu_en),
        .done           (done),
        .overflow       (overflow),
        .tr             (tr_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_fresh = 0;
    logic [32:0] exp_q[$];
    bit          en_seen = 1'b0;
    bit          rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Expected words of the record currently on the commit bus.
    task automatic push_rec();
        logic [31:0] w[6];
        w[0] = commit_pc;
        w[1] = commit_inst;
        w[2] = {commit_halt, commit_reg_we, commit_dmem_we, 24'h0, commit_reg_wa};
        w[3] = commit_reg_wd;
        w[4] = commit_dmem_wa;
        w[5] = commit_dmem_wd;
        for (int i = 0; i < W; i++) exp_q.push_back({(i == W - 1), w[i]});
    endtask

    task automatic rand_fields();
        commit_pc      = $urandom;
        commit_inst    = $urandom;
        commit_reg_wd  = $urandom;
        commit_dmem_wa = $urandom;
        commit_dmem_wd = $urandom;
        commit_reg_wa  = 5'($urandom);
        commit_reg_we  = 1'($urandom);
        commit_dmem_we = 1'($urandom);
        commit_halt    = 1'b0;
    endtask

    // CPU model: its commit registers advance only after an edge with global_en high.
    task automatic step(input int kind, output bit presented);
        @(posedge clk);
        #1;
        if (rand_ready) tr_if.tr_ready = ($urandom_range(0, 2) != 0);
        presented = en_seen;
        if (en_seen) begin
            case (kind)
                0: commit = 1'b0;
                1: begin commit = 1'b1; rand_fields(); end
                2: begin
                    commit = 1'b1; commit_halt = 1'b0;
                    commit_pc = 32'h0; commit_inst = 32'h00A00093;
                    commit_reg_we = 1'b1; commit_reg_wa = 5'd1; commit_reg_wd = 32'h0000000A;
                    commit_dmem_we = 1'b0; commit_dmem_wa = 32'h00000100; commit_dmem_wd = 32'hCAFEF00D;
                end
                3: begin commit = ($urandom_range(0, 3) != 0); rand_fields(); end
                default: begin commit = 1'b1; rand_fields(); commit_halt = 1'b1; commit_inst = 32'h80000000; end
            endcase
            if (commit) begin
                n_fresh++;
                if (kind == 2) begin
                    exp_q.push_back({1'b0, 32'h00000000});
                    exp_q.push_back({1'b0, 32'h00A00093});
                    exp_q.push_back({1'b0, 32'h40000001});
                    exp_q.push_back({(W == 4), 32'h0000000A});
                    if (W == 6) begin
                        exp_q.push_back({1'b0, 32'h00000100});
                        exp_q.push_back({1'b1, 32'hCAFEF00D});
                    end
                end else begin
                    push_rec();
                end
            end
        end
    endtask

    task automatic drain(input string name);
        bit p;
        int k;
        k = 0;
        rand_ready = 1'b0;
        tr_if.tr_ready = 1'b1;
        while (exp_q.size() != 0 && k < 400) begin
            step(0, p);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) en_seen = cpu_en;

    // Monitor: compare every transferred word against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (!tr_if.tr_valid) begin
                chk("empty_data", tr_if.tr_data, 0);
                chk("empty_last", tr_if.tr_last, 0);
            end
            if (prev_stall && tr_if.tr_valid) begin
                chk("stall_data", tr_if.tr_data, prev_data);
                chk("stall_last", tr_if.tr_last, prev_last);
            end
            if (tr_if.tr_valid && tr_if.tr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: actual %0h required none", tr_if.tr_data);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("word_data", tr_if.tr_data, e[31:0]);
                    chk("word_last", tr_if.tr_last, e[32]);
                end
            end
            prev_stall = tr_if.tr_valid && !tr_if.tr_ready;
            prev_data  = tr_if.tr_data;
            prev_last  = tr_if.tr_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit p;
        int k;
        tr_if.tr_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_valid", tr_if.tr_valid, 0);
        chk("rst_data", tr_if.tr_data, 0);
        chk("rst_last", tr_if.tr_last, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b1;

        // Frozen commit while idle must never be captured
        commit = 1'b1;
        rand_fields();
        for (int i = 0; i < 5; i++) begin
            step(1, p);
            chk("frozen_no_en", p, 0);
            chk("frozen_valid", tr_if.tr_valid, 0);
        end
        start = 1'b1;
        step(1, p);
        start = 1'b0;
        chk("start_cpu_en", cpu_en, 1);
        tr_if.tr_ready = 1'b1;
        n_fresh = 0;
        repeat (8) step(1, p);
        chk("enabled_captures", n_fresh, 8);
        drain("frozen_drain");

        // Single known record and first-word latency
        step(2, p);
        chk("single_presented", p, 1);
        step(0, p);
        chk("single_latency", tr_if.tr_valid, 1);
        drain("single_drain");

        // Backpressure: exactly DEPTH captures, then cpu_en returns after the first pop
        tr_if.tr_ready = 1'b0;
        n_fresh = 0;
        repeat (40) step(1, p);
        chk("bp_captures", n_fresh, DEPTH);
        chk("bp_cpu_en", cpu_en, 0);
        chk("bp_overflow", overflow, 0);
        tr_if.tr_ready = 1'b1;
        for (int i = 1; i <= W; i++) begin
            step(1, p);
            if (i < W) chk("bp_en_held", cpu_en, 0);
            else chk("bp_en_return", cpu_en, 1);
        end

        // Full FIFO with a last-word pop and a capture on the same edge
        tr_if.tr_ready = 1'b0;
        repeat (10) step(1, p);
        chk("full_cpu_en", cpu_en, 0);
        tr_if.tr_ready = 1'b1;
        repeat (W - 1) step(0, p);
        chk("full_last_word", tr_if.tr_last, 1);
        force dut.en_q = 1'b1;
        commit = 1'b1;
        rand_fields();
        push_rec();
        @(posedge clk);
        #1;
        release dut.en_q;
        commit = 1'b0;
        tr_if.tr_ready = 1'b0;
        chk("full_count", dut.count, DEPTH);
        chk("full_overflow", overflow, 0);
        drain("full_drain");

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        repeat (300) step(3, p);
        drain("rand_drain");
        chk("rand_overflow", overflow, 0);

        // Halt record, drain to done, restart
        tr_if.tr_ready = 1'b1;
        k = 0;
        p = 1'b0;
        while (!p && k < 20) begin
            step(4, p);
            k++;
        end
        chk("halt_presented", p, 1);
        step(0, p);
        chk("halt_cpu_en", cpu_en, 0);
        chk("halt_done_early", done, 0);
        k = 0;
        while (!done && k < 60) begin
            step(0, p);
            k++;
        end
        chk("halt_done", done, 1);
        chk("halt_drained", exp_q.size(), 0);
        chk("halt_valid", tr_if.tr_valid, 0);
        start = 1'b1;
        step(0, p);
        start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_cpu_en", cpu_en, 1);

        // Asynchronous reset in the middle of a record
        tr_if.tr_ready = 1'b0;
        step(1, p);
        chk("mid_presented", p, 1);
        step(0, p);
        tr_if.tr_ready = 1'b1;
        step(0, p);
        step(0, p);
        tr_if.tr_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", tr_if.tr_valid, 0);
        chk("async_data", tr_if.tr_data, 0);
        chk("async_cpu_en", cpu_en, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        commit = 1'b0;
        chk("post_rst_valid", tr_if.tr_valid, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_overflow", overflow, 0);
        step(0, p);
        step(0, p);
        chk("post_rst_idle", cpu_en, 0);
        start = 1'b1;
        step(0, p);
        start = 1'b0;
        chk("post_rst_start", cpu_en, 1);
        tr_if.tr_ready = 1'b1;
        step(1, p);
        chk("post_rst_presented", p, 1);
        drain("post_rst_drain");
        chk("final_overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
